keypad_scan: RTL and testbench
==============================

KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, is the number of clk cycles per scan tick (1 kHz at 50 MHz); legal range 2..2^20.
REQ-002 Parameter DEBOUNCE_CNT, default 8, is the number of consecutive matching scan-tick samples required for press or release; legal range 1..15.
REQ-003 clk  input  1  system clock; single clock domain, all flops on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 o_col  output  4  column drive, active-low, one-hot-zero.
REQ-006 i_row  input  4  row sense, active-low, externally pulled up, asynchronous to clk.
REQ-007 o_key_code  output  4  key index = row*4 + col; holds its last value until the next valid press.
REQ-008 o_key_valid  output  1  single-cycle pulse on each debounced press.
REQ-009 o_key_held  output  1  level; high while a debounced key remains pressed.
REQ-010 o_key_release  output  1  single-cycle pulse on each debounced release.

Function
REQ-011 i_row SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value (row_s).
REQ-012 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; scan tick = 1 for one cycle when count == SCAN_DIV-1.
REQ-013 FSM states: SCAN, DEBOUNCE, HOLD, RELEASE; all transitions occur only on scan-tick cycles.
REQ-014 SCAN, on tick: sample row_s for the current column.
  - exactly one row low -> latch row/col, set stable count = 1, go DEBOUNCE;
  - else advance column (3 -> 0 wrap); o_col = ~(1 << col).
REQ-015 In SCAN, a row_s pattern with two or more rows low SHALL be treated as no key (ghosting rejection).
REQ-016 DEBOUNCE: column frozen; on each tick, compare row_s to the latched pattern.
  - match -> increment count; when count reaches DEBOUNCE_CNT, assert o_key_valid and load o_key_code in the same cycle, go HOLD;
  - mismatch -> go SCAN, advance column, emit no pulse.
REQ-017 With DEBOUNCE_CNT = 1, o_key_valid SHALL fire on the first detecting tick, and the FSM SHALL enter HOLD directly.
REQ-018 HOLD: o_key_held = 1; column frozen; on a tick with row_s all high -> go RELEASE with count = 1; any low row -> stay in HOLD.
REQ-019 RELEASE: o_key_held stays 1; on each tick:
  - row_s all high -> increment count; at DEBOUNCE_CNT, assert o_key_release, deassert o_key_held, advance column, go SCAN;
  - otherwise -> return to HOLD, emit no pulse.
REQ-020 A second key pressed while in HOLD/RELEASE SHALL be ignored; only the latched key governs release.
REQ-021 o_key_valid and o_key_release SHALL never be high in the same cycle; each is exactly 1 cycle wide.
REQ-022 Worst-case press latency: 2 sync cycles + up to 4 ticks for the column to arrive + DEBOUNCE_CNT ticks.

Reset
REQ-023 On rst: state = SCAN, col = 0, o_col = 4'b1110, synchronizer = 4'b1111, prescaler = 0, debounce count = 0, o_key_code = 0, o_key_valid = 0, o_key_held = 0, o_key_release = 0.
REQ-024 rst asserted mid-press or mid-debounce SHALL abort with no pulse; a key still held after reset SHALL be re-detected and re-debounced from SCAN.

Structure
REQ-025 The shared package SHALL hold: the FSM state encoding, the key-code width (4), the column/row count (4), and default SCAN_DIV and DEBOUNCE_CNT.
REQ-026 The prescaler SHALL be a sub-module scan_tick_gen (inputs clk, rst, SCAN_DIV; output 1-cycle tick); the FSM, synchronizer and counters SHALL reside in keypad_scan.

Verification
REQ-027 Bench parameters: SCAN_DIV = 4, DEBOUNCE_CNT = 3.
REQ-028 Clean press, row 2 low when o_col = 4'b1101, held 40 ticks -> one o_key_valid with o_key_code = 9; o_key_held = 1 until 3 ticks after release; one o_key_release.
REQ-029 Bounce: row 0 low on col 3 for 2 ticks, high for 1, then low for 5 -> no pulse on the first burst; exactly one o_key_valid with code 3 after the second burst.
REQ-030 Ghost: rows 1 and 3 both low on col 0 -> no o_key_valid; column keeps cycling 1110, 1101, 1011, 0111, 1110.
REQ-031 Second key: key 5 held, then key 10 pressed and released, then key 5 released -> only one valid (code 5) and one release.
REQ-032 Reset during DEBOUNCE, with key 0 held throughout -> o_col = 1110 the cycle after rst; o_key_valid fires once, ≥ 3 ticks after rst deasserts.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// The row helpers decode an active-low row pattern.
package keypad_scan_pkg;

    localparam int KEY_W            = 4;
    localparam int NUM_LINES        = 4;
    localparam int SCAN_DIV_DEF     = 50000;
    localparam int DEBOUNCE_CNT_DEF = 8;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HOLD,
        ST_RELEASE
    } state_e;

    // True when exactly one row line is pulled low (multi-row = ghosting).
    function automatic logic single_low(input logic [NUM_LINES-1:0] row);
        logic [NUM_LINES-1:0] act;
        act = ~row;
        return (act != '0) &&
               ((act & (act - {{(NUM_LINES-1){1'b0}}, 1'b1})) == '0);
    endfunction

    function automatic logic [1:0] low_index(input logic [NUM_LINES-1:0] row);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (!row[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan_tick_gen.sv
// Free-running prescaler: one-cycle tick every SCAN_DIV clocks.
module scan_tick_gen
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic o_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        o_tick = (cnt_q == CW'(SCAN_DIV - 1));
        cnt_d  = o_tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with ghost rejection, press/release debounce
// and single-cycle valid/release pulses.
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEF,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    output logic [3:0]       o_col,
    input  logic [3:0]       i_row,
    output logic [KEY_W-1:0] o_key_code,
    output logic             o_key_valid,
    output logic             o_key_held,
    output logic             o_key_release
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CNT);

    logic             tick;
    logic [3:0]       row_meta_q, row_s_q;
    state_e           state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       pat_q, pat_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             release_q, release_d;

    scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .o_tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        pat_d     = pat_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        release_d = 1'b0;
        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (single_low(row_s_q)) begin
                        row_d = low_index(row_s_q);
                        pat_d = row_s_q;
                        cnt_d = 4'd1;
                        if (cnt_d == DB_LAST) begin
                            valid_d = 1'b1;
                            code_d  = {low_index(row_s_q), col_q};
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_s_q == pat_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DB_LAST) begin
                            valid_d = 1'b1;
                            code_d  = {row_q, col_q};
                            state_d = ST_HOLD;
                        end
                    end else begin
                        col_d   = col_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
                ST_HOLD: begin
                    // Column stays frozen, so only keys in the latched column can hold us here.
                    if (row_s_q == 4'hF) begin
                        cnt_d = 4'd1;
                        if (cnt_d == DB_LAST) begin
                            release_d = 1'b1;
                            col_d     = col_q + 2'd1;
                            state_d   = ST_SCAN;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (row_s_q == 4'hF) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DB_LAST) begin
                            release_d = 1'b1;
                            col_d     = col_q + 2'd1;
                            state_d   = ST_SCAN;
                        end
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= 4'hF;
            row_s_q    <= 4'hF;
            state_q    <= ST_SCAN;
            col_q      <= '0;
            row_q      <= '0;
            pat_q      <= 4'hF;
            cnt_q      <= '0;
            code_q     <= '0;
            valid_q    <= 1'b0;
            release_q  <= 1'b0;
        end else begin
            row_meta_q <= i_row;
            row_s_q    <= row_meta_q;
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            pat_q      <= pat_d;
            cnt_q      <= cnt_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            release_q  <= release_d;
        end
    end

    assign o_col         = ~(4'b0001 << col_q);
    assign o_key_code    = code_q;
    assign o_key_valid   = valid_q;
    assign o_key_release = release_q;
    assign o_key_held    = (state_q == ST_HOLD) || (state_q == ST_RELEASE);

endmodule

// File: tb/tb_keypad_scan.sv
// Keypad scanner bench: key-matrix model, scoreboard of expected press/release
// events, and a monitor that checks each pulse against the queue.
module tb_keypad_scan;

    localparam int SD = 4;
    localparam int DB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] o_col, i_row, o_key_code;
    logic       o_key_valid, o_key_held, o_key_release;
    logic [15:0] keys = '0;

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .clk           (clk),
        .rst           (rst),
        .o_col         (o_col),
        .i_row         (i_row),
        .o_key_code    (o_key_code),
        .o_key_valid   (o_key_valid),
        .o_key_held    (o_key_held),
        .o_key_release (o_key_release)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key shorts its row to its column line.
    always_comb begin
        i_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !o_col[c]) i_row[r] = 1'b0;
    end

    typedef struct packed {
        logic       rel;
        logic [3:0] code;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;
    int  n_checks = 0;
    int  n_fail   = 0;
    logic prev_v = 1'b0, prev_r = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_key(input int k);
        exp_q.push_back('{rel: 1'b0, code: 4'(k)});
        exp_q.push_back('{rel: 1'b1, code: 4'(k)});
    endtask

    // Monitor: every pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
            prev_r <= 1'b0;
        end else begin
            if (o_key_valid && o_key_release) chk("valid_release_overlap", 1, 0);
            if (o_key_valid || o_key_release) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event_code", {27'd0, o_key_release, o_key_code}, 32'hFFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_is_release", o_key_release, mon_e.rel);
                    chk("event_code", o_key_code, mon_e.code);
                    chk("pulse_width", o_key_valid ? prev_v : prev_r, 0);
                    chk("held_at_event", o_key_held, o_key_valid);
                end
            end
            prev_v <= o_key_valid;
            prev_r <= o_key_release;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic held_ok;
        logic [3:0] prev_col;
        int k;

        rst = 1'b1;
        clk_n(3);
        chk("reset_col", o_col, 4'b1110);
        chk("reset_valid", o_key_valid, 0);
        chk("reset_held", o_key_held, 0);
        chk("reset_release", o_key_release, 0);
        chk("reset_code", o_key_code, 0);

        // Reset in the middle of debouncing key 0, key held throughout.
        keys[0] = 1'b1;
        clk_n(1);
        rst = 1'b0;
        clk_n(9);
        rst = 1'b1;
        clk_n(1);
        rst = 1'b0;
        chk("col_after_rst", o_col, 4'b1110);
        expect_key(0);
        lat = 0;
        while (!o_key_valid && lat < 100) begin
            clk_n(1);
            lat++;
        end
        chk("rst_valid_seen", o_key_valid, 1);
        chk("rst_valid_latency_ge_12", lat >= 3 * SD, 1);
        keys[0] = 1'b0;
        clk_n(10 * SD);

        // Clean press of key 9 (row 2, column 1), then release latency.
        expect_key(9);
        keys[9] = 1'b1;
        clk_n(40 * SD);
        chk("clean_held", o_key_held, 1);
        keys[9] = 1'b0;
        lat = 0;
        held_ok = 1'b1;
        while (!o_key_release && lat < 100) begin
            if (!o_key_held) held_ok = 1'b0;
            clk_n(1);
            lat++;
        end
        chk("clean_held_until_release", held_ok, 1);
        chk("clean_release_latency_window", (lat >= 10) && (lat <= 16), 1);
        clk_n(10 * SD);

        // Bounce on key 3: short burst aligned to column 3, then a long press.
        expect_key(3);
        lat = 0;
        while (o_col != 4'b0111 && lat < 100) begin
            clk_n(1);
            lat++;
        end
        chk("bounce_col3_reached", o_col, 4'b0111);
        keys[3] = 1'b1;
        clk_n(2 * SD);
        keys[3] = 1'b0;
        clk_n(SD);
        keys[3] = 1'b1;
        clk_n(12 * SD);
        keys[3] = 1'b0;
        clk_n(10 * SD);

        // Ghost: rows 1 and 3 on column 0; column must keep rotating.
        keys[4]  = 1'b1;
        keys[12] = 1'b1;
        prev_col = o_col;
        for (int i = 0; i < 12; i++) begin
            clk_n(SD);
            chk("ghost_col_rotate", o_col, {prev_col[2:0], prev_col[3]});
            prev_col = o_col;
        end
        keys[4]  = 1'b0;
        keys[12] = 1'b0;
        clk_n(4 * SD);

        // Second key (10) while key 5 is held must be ignored.
        expect_key(5);
        keys[5] = 1'b1;
        clk_n(15 * SD);
        keys[10] = 1'b1;
        clk_n(8 * SD);
        keys[10] = 1'b0;
        clk_n(5 * SD);
        keys[5] = 1'b0;
        clk_n(10 * SD);

        // Random presses and sub-debounce glitches.
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) begin
                keys[k] = 1'b1;
                clk_n($urandom_range(1, 2 * SD));
                keys[k] = 1'b0;
                clk_n(6 * SD);
            end else begin
                expect_key(k);
                keys[k] = 1'b1;
                clk_n($urandom_range(12, 30) * SD);
                keys[k] = 1'b0;
                clk_n($urandom_range(8, 15) * SD);
            end
        end

        clk_n(4 * SD);
        chk("pending_events", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
